// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_pkg
//  Description : Shared DES constants for the f-function datapath: half-block
//                and subkey widths, the E expansion and P permutation tables,
//                the eight S-box tables, and helpers that apply them.
//                Tables are written in FIPS 46-3 numbering (bit 1 = MSB), so
//                FIPS bit i of a W-bit vector lives at vector index W-i.
//  Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

  localparam int DES_HALF_W   = 32;
  localparam int DES_SUBKEY_W = 48;

  // E: output bit j+1 takes R bit E_TABLE[j]
  localparam int unsigned E_TABLE [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  // P: output bit j+1 takes S-box output bit P_TABLE[j]
  localparam int unsigned P_TABLE [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // S-boxes, each stored as row*16 + column
  localparam logic [3:0] SBOX [8][64] = '{
    '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8, 4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
      4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1, 4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
      4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11, 4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
      4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7, 4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
    '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4, 4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
      4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14, 4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
      4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1, 4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
      4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2, 4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
    '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5, 4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
      4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10, 4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
      4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0, 4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
      4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7, 4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
    '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10, 4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
      4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3, 4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
      4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13, 4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
      4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8, 4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
    '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6, 4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
      4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1, 4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
      4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
      4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13, 4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
    '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8, 4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
      4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5, 4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
      4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3, 4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
      4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10, 4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
    '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13, 4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
      4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10, 4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
      4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14, 4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
      4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7, 4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
    '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1, 4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
      4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4, 4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
      4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2, 4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
      4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13, 4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}
  };

  function automatic logic [DES_SUBKEY_W-1:0] des_expand(input logic [DES_HALF_W-1:0] r);
    logic [DES_SUBKEY_W-1:0] e;
    e = '0;
    for (int j = 0; j < DES_SUBKEY_W; j++) begin
      e[DES_SUBKEY_W-1-j] = r[DES_HALF_W-E_TABLE[j]];
    end
    return e;
  endfunction

  function automatic logic [DES_HALF_W-1:0] des_permute(input logic [DES_HALF_W-1:0] s);
    logic [DES_HALF_W-1:0] p;
    p = '0;
    for (int j = 0; j < DES_HALF_W; j++) begin
      p[DES_HALF_W-1-j] = s[DES_HALF_W-P_TABLE[j]];
    end
    return p;
  endfunction

  // Row comes from the outer bits (b1,b6), column from the inner four.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [5:0] x);
    return SBOX[n][{x[5], x[0], x[4:1]}];
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_ffunc_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : des_ffunc_pipe_if
//  Description : Valid/ready bundle for the DES f-function pipe.
//                Input side : in_valid, in_ready, in_r, in_subkey, in_tag
//                Output side: out_valid, out_ready, out_f, out_tag
//                master = traffic source/sink, slave = the pipe itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface des_ffunc_pipe_if
  import des_pkg::*;
#(
  parameter int TAG_W = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DES_HALF_W-1:0]   in_r;
  logic [DES_SUBKEY_W-1:0] in_subkey;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [DES_HALF_W-1:0]   out_f;
  logic [TAG_W-1:0]        out_tag;

  modport master (
    output in_valid, in_r, in_subkey, in_tag, out_ready,
    input  in_ready, out_valid, out_f, out_tag
  );

  modport slave (
    input  in_valid, in_r, in_subkey, in_tag, out_ready,
    output in_ready, out_valid, out_f, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/des_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : des_sbox1 .. des_sbox8
//  Description : The eight DES S-boxes, 6-bit in (x[5] = FIPS b1),
//                4-bit out, purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_sbox1 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
  assign y = sbox_lookup(3'd0, x);
endmodule

module des_sbox2 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
  assign y = sbox_lookup(3'd1, x);
endmodule

module des_sbox3 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
  assign y = sbox_lookup(3'd2, x);
endmodule

module des_sbox4 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
  assign y = sbox_lookup(3'd3, x);
endmodule

module des_sbox5 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
  assign y = sbox_lookup(3'd4, x);
endmodule

module des_sbox6 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
  assign y = sbox_lookup(3'd5, x);
endmodule

module des_sbox7 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
  assign y = sbox_lookup(3'd6, x);
endmodule

module des_sbox8 import des_pkg::*; (input logic [5:0] x, output logic [3:0] y);
  assign y = sbox_lookup(3'd7, x);
endmodule
`default_nettype wire

// File: rtl/des_sbox_bank.sv
`default_nettype none
// ============================================================================
//  Module      : des_sbox_bank
//  Description : All eight S-boxes side by side. Purely combinational.
//                x [47:0] : E(R) xor K, bits [47:42] feed S1 ... [5:0] feed S8
//                y [31:0] : S1 output at [31:28] ... S8 output at [3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module des_sbox_bank
  import des_pkg::*;
(
  input  logic [DES_SUBKEY_W-1:0] x,
  output logic [DES_HALF_W-1:0]   y
);
  des_sbox1 u_s1 (.x(x[47:42]), .y(y[31:28]));
  des_sbox2 u_s2 (.x(x[41:36]), .y(y[27:24]));
  des_sbox3 u_s3 (.x(x[35:30]), .y(y[23:20]));
  des_sbox4 u_s4 (.x(x[29:24]), .y(y[19:16]));
  des_sbox5 u_s5 (.x(x[23:18]), .y(y[15:12]));
  des_sbox6 u_s6 (.x(x[17:12]), .y(y[11:8]));
  des_sbox7 u_s7 (.x(x[11:6]),  .y(y[7:4]));
  des_sbox8 u_s8 (.x(x[5:0]),   .y(y[3:0]));
endmodule
`default_nettype wire

// File: rtl/des_ffunc_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : des_ffunc_pipe
//  Description : Pipelined DES round function f(R,K) = P(S(E(R) xor K)) with
//                valid/ready flow control and an opaque sideband tag.
//                clk  : rising-edge clock
//                rst  : synchronous, active-high; drops all in-flight work
//                bus  : des_ffunc_pipe_if.slave (in_* request, out_* result)
//                Build option DES_FFUNC_SREG_EN: when defined, E/xor result is
//                registered (stage A) ahead of the S-boxes, latency 2; when
//                undefined, a single output register, latency 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_ffunc_pipe
  import des_pkg::*;
#(
  parameter int TAG_W = 4
)
(
  input logic             clk,
  input logic             rst,
  des_ffunc_pipe_if.slave bus
);

  logic [DES_SUBKEY_W-1:0] sbox_in;
  logic [DES_HALF_W-1:0]   sbox_out;
  logic                    stage_valid;   // an operation is ready to enter stage B
  logic [TAG_W-1:0]        stage_tag;

  logic                    out_valid_q;
  logic [DES_HALF_W-1:0]   out_f_q;
  logic [TAG_W-1:0]        out_tag_q;

  // Output register can take new content when empty or being drained now.
  logic out_load;
  assign out_load = !out_valid_q || bus.out_ready;

`ifdef DES_FFUNC_SREG_EN
  logic                    a_valid;
  logic [DES_SUBKEY_W-1:0] a_x;
  logic [TAG_W-1:0]        a_tag;
  logic                    a_advance;

  assign a_advance    = a_valid && out_load;
  assign bus.in_ready = !a_valid || a_advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_x     <= '0;
      a_tag   <= '0;
    end else if (bus.in_ready) begin
      a_valid <= bus.in_valid;
      if (bus.in_valid) begin
        a_x   <= des_expand(bus.in_r) ^ bus.in_subkey;
        a_tag <= bus.in_tag;
      end
    end
  end

  assign sbox_in     = a_x;
  assign stage_valid = a_valid;
  assign stage_tag   = a_tag;
`else
  assign bus.in_ready = out_load;
  assign sbox_in      = des_expand(bus.in_r) ^ bus.in_subkey;
  assign stage_valid  = bus.in_valid;
  assign stage_tag    = bus.in_tag;
`endif

  des_sbox_bank u_sbox_bank (
    .x (sbox_in),
    .y (sbox_out)
  );

  // Data only moves on a valid load, so a stalled result holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
      out_tag_q   <= '0;
    end else if (out_load) begin
      out_valid_q <= stage_valid;
      if (stage_valid) begin
        out_f_q   <= des_permute(sbox_out);
        out_tag_q <= stage_tag;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_f     = out_f_q;
  assign bus.out_tag   = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_des_ffunc_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_des_ffunc_pipe
//  Description : Directed self-checking bench for des_ffunc_pipe: reset state,
//                single-op latency, back-to-back stream, stall with full pipe,
//                random handshake traffic against an in-order scoreboard, and
//                reset with work in flight. Expected f values are hand-derived.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_des_ffunc_pipe;
  import des_pkg::*;

  localparam int TAG_W = 4;
`ifdef DES_FFUNC_SREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NVEC  = 6;
  localparam int TOTAL = 200;

  logic clk = 1'b0;
  logic rst;

  des_ffunc_pipe_if #(.TAG_W(TAG_W)) bus ();

  des_ffunc_pipe #(.TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] vec_r [NVEC];
  logic [47:0] vec_k [NVEC];
  logic [31:0] vec_f [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  int          exp_q [$];
  int          k;
  int          idx;
  logic        hold_prev;
  logic [31:0] prev_f;
  logic [3:0]  prev_tag;
  logic [3:0]  t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int vi, input logic [3:0] tg);
    bus.in_valid  = v;
    bus.in_r      = vec_r[vi];
    bus.in_subkey = vec_k[vi];
    bus.in_tag    = tg;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_r[0] = 32'hF0AAF0AA; vec_k[0] = 48'h1B02EFFC7072; vec_f[0] = 32'h234AA9BB;
    vec_r[1] = 32'h00000000; vec_k[1] = 48'h000000000000; vec_f[1] = 32'hD8D8DBBC;
    vec_r[2] = 32'hFFFFFFFF; vec_k[2] = 48'hFFFFFFFFFFFF; vec_f[2] = 32'hD8D8DBBC;
    vec_r[3] = 32'h00000000; vec_k[3] = 48'hFFFFFFFFFFFF; vec_f[3] = 32'h38DBF9CB;
    vec_r[4] = 32'hFFFFFFFF; vec_k[4] = 48'h000000000000; vec_f[4] = 32'h38DBF9CB;
    vec_r[5] = 32'h00000000; vec_k[5] = 48'h041041041041; vec_f[5] = 32'hD73559C1;

    // Reset with in_valid asserted: nothing may be taken in.
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 0, 4'hF);
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", bus.out_valid, 1'b0);
    check("post_rst_out_f", bus.out_f, 32'h0);
    check("post_rst_out_tag", bus.out_tag, 4'h0);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    repeat (LAT) @(negedge clk);
    check("post_rst_idle", bus.out_valid, 1'b0);

    // Single operation: latency and reference value.
    drive(1'b1, 0, 4'd3);
    #1;
    check("single_in_ready", bus.in_ready, 1'b1);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("single_lat_valid", bus.out_valid, c == LAT);
    end
    check("single_out_f", bus.out_f, 32'h234AA9BB);
    check("single_out_tag", bus.out_tag, 4'd3);
    @(negedge clk);
    check("single_consumed", bus.out_valid, 1'b0);

    // Back-to-back stream: one result per cycle in order.
    for (int c = 0; c < NVEC + LAT + 1; c++) begin
      if (c >= LAT && c - LAT < NVEC) begin
        t = 4'(c - LAT + 8);
        check("stream_valid", bus.out_valid, 1'b1);
        check("stream_f", bus.out_f, vec_f[c-LAT]);
        check("stream_tag", bus.out_tag, t);
      end else begin
        check("stream_idle", bus.out_valid, 1'b0);
      end
      if (c < NVEC) drive(1'b1, c, 4'(c + 8));
      else bus.in_valid = 1'b0;
      #1;
      check("stream_in_ready", bus.in_ready, 1'b1);
      @(negedge clk);
    end

    // Stall: pipe fills to its depth, then in_ready drops and output holds.
    bus.out_ready = 1'b0;
    k = 0;
    for (int s = 0; s < 7; s++) begin
      drive(1'b1, k % NVEC, 4'(k));
      #1;
      check("stall_in_ready", bus.in_ready, s < LAT);
      if (s >= LAT) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_f", bus.out_f, vec_f[0]);
        check("stall_tag", bus.out_tag, 4'd0);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(k);
        k++;
      end
      @(negedge clk);
    end

    // Random handshake traffic against the in-order scoreboard.
    hold_prev = 1'b0;
    prev_f    = '0;
    prev_tag  = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold_prev) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_f", bus.out_f, prev_f);
        check("hold_tag", bus.out_tag, prev_tag);
      end
      bus.out_ready = (k >= TOTAL) ? 1'b1 : 1'($urandom_range(0, 1));
      if (k < TOTAL && $urandom_range(0, 2) != 0) drive(1'b1, k % NVEC, 4'(k));
      else bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_spurious", bus.out_valid, 1'b0);
        end else begin
          idx = exp_q.pop_front();
          t   = 4'(idx);
          check("sb_f", bus.out_f, vec_f[idx % NVEC]);
          check("sb_tag", bus.out_tag, t);
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_f    = bus.out_f;
      prev_tag  = bus.out_tag;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(k);
        k++;
      end
      @(negedge clk);
      if (k >= TOTAL && exp_q.size() == 0 && !bus.out_valid) break;
    end
    bus.in_valid = 1'b0;
    check("sb_all_sent", k, TOTAL);
    check("sb_drained", exp_q.size(), 0);
    check("sb_idle", bus.out_valid, 1'b0);

    // Reset with two operations in flight.
    bus.out_ready = 1'b1;
    drive(1'b1, 1, 4'd1);
    @(negedge clk);
    drive(1'b1, 5, 4'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_out_f", bus.out_f, 32'h0);
    check("midrst_out_tag", bus.out_tag, 4'h0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("midrst_no_stale", bus.out_valid, 1'b0);
    end
    drive(1'b1, 5, 4'd7);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("after_rst_lat_valid", bus.out_valid, c == LAT);
    end
    check("after_rst_f", bus.out_f, 32'hD73559C1);
    check("after_rst_tag", bus.out_tag, 4'd7);
    @(negedge clk);
    check("after_rst_consumed", bus.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/des_ffunc_pipe.md
DES_FFUNC_PIPE -- requirements
Module: des_ffunc_pipe

Interface
REQ-001 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each f-function operation.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: upstream presents operation.
REQ-005 SHALL have port in_ready, output, 1: block accepts operation this cycle.
REQ-006 SHALL have port in_r, input, 32: right half R, bit 31 = FIPS 46-3 bit 1.
REQ-007 SHALL have port in_subkey, input, 48: round subkey K, bit 47 = FIPS bit 1.
REQ-008 SHALL have port in_tag, input, TAG_W: opaque sideband, returned unchanged.
REQ-009 SHALL have port out_valid, output, 1: result available.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-011 SHALL have port out_f, output, 32: f(R,K), bit 31 = FIPS bit 1.
REQ-012 SHALL have port out_tag, output, TAG_W: tag of the operation on out_f.

Function
REQ-013 SHALL compute f(R,K) = P(S1..S8(E(R) xor K)) per FIPS 46-3 tables.
REQ-014 Stage A SHALL register X = E(in_r) xor in_subkey (48 b) plus tag plus valid.
REQ-015 Stage B SHALL feed X[47:42] to S1 through X[5:0] to S8, MSB-first per 6-bit chunk.
REQ-016 Stage B SHALL concatenate S1 output at bits [31:28] through S8 at [3:0], apply P, and register the result into out_f/out_tag/out_valid.
REQ-017 Each stage SHALL load when it is empty or its content is leaving in the same cycle; handshake fires on valid && ready.
REQ-018 in_ready SHALL equal !stageA_valid || stageA_advance, with no combinational path from in_valid.
REQ-019 While out_valid && !out_ready, out_f and out_tag SHALL hold stable and no data SHALL be lost or duplicated.
REQ-020 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-021 Latency SHALL be 2 cycles from accept to out_valid (1 cycle without DES_FFUNC_SREG_EN).
REQ-022 Simultaneous accept at input and drain at output of a full pipe SHALL move all stages with no bubble.
REQ-023 Operations SHALL leave in strict acceptance order.

Reset
REQ-024 On rst all valid flags SHALL clear; out_valid=0, out_f=0, out_tag=0, in_ready=1 in the following cycle.
REQ-025 rst asserted mid-operation SHALL discard every in-flight operation; no result SHALL emerge after reset.
REQ-026 in_valid SHALL be ignored while rst is high.

Configuration
REQ-027 Macro DES_FFUNC_SREG_EN defined: stage A register present, latency 2.
REQ-028 DES_FFUNC_SREG_EN undefined: E/xor feed the S-boxes combinationally into the single output register, latency 1, in_ready = !out_valid || out_ready; all other requirements unchanged.

Structure
REQ-029 Shared package des_pkg SHALL hold the E and P tables as constants, plus widths DES_HALF_W=32 and DES_SUBKEY_W=48.
REQ-030 Sub-module des_sbox_bank SHALL wrap the eight existing des_sbox1..des_sbox8 instances: 48 in, 32 out, purely combinational.

Verification
REQ-031 in_r=F0AAF0AA, in_subkey=1B02EFFC7072, tag=3, out_ready=1 -> after 2 cycles out_f=234AA9BB, out_tag=3.
REQ-032 Back-to-back 64 random ops, out_ready=1 -> one result per cycle, all equal golden-model f, tags in order.
REQ-033 out_ready low 5 cycles with pipe full -> in_ready=0 once full, out_f/out_tag stable, no loss after release.
REQ-034 Random in_valid/out_ready toggling, 10k ops -> scoreboard exact match, no drops/duplicates.
REQ-035 rst pulsed with 2 ops in flight -> out_valid=0 next cycle, no stale result thereafter, next op correct.
REQ-036 Rerun REQ-031 and REQ-032 with DES_FFUNC_SREG_EN undefined -> same values, latency 1.
